// File: rtl/mips_fetch_queue.sv
// Instruction-fetch front end: owns PC, keeps up to DEPTH imem reads in flight and
// buffers returned words for decode. Optional macro FETCH_HLT_STOP_EN: a fetched HLT word halts issue.
module mips_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk1,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [AW-1:0]              imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  input  logic                       halt,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [31:0]                if_ir,
  output logic [31:0]                if_npc,
  output logic [$clog2(DEPTH):0]     if_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshakes: imem request transfers when imem_req && imem_gnt; a response is one
  // imem_rvalid cycle, in request order; decode takes the head when if_valid && if_ready.

  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q  [DEPTH];
  logic [31:0]   ir_d  [DEPTH];
  logic [AW-1:0] npc_q [DEPTH];
  logic [AW-1:0] npc_d [DEPTH];
  logic [AW-1:0] tag_q [DEPTH];
  logic [AW-1:0] tag_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, stale_q, stale_d;
  logic          halted_q, halted_d;
  logic          rst_state_q;
  logic [CW+1:0] credit;
  logic          grant, rsp_live, push, pop;

  // Credit counts queued words plus every request still owed a response, stale or not.
  assign credit    = (CW+2)'(count_q) + (CW+2)'(outst_q) + (CW+2)'(stale_q);
  assign imem_req  = !rst_state_q && !halted_q && !redirect && (credit < (CW+2)'(DEPTH));
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  assign rsp_live  = imem_rvalid && (stale_q == '0);
  assign push      = rsp_live && !redirect;
  assign if_valid  = (count_q != '0);
  assign pop       = if_valid && if_ready && !redirect;
  assign if_ir     = if_valid ? ir_q[rd_ptr_q] : 32'h0;
  assign if_npc    = if_valid ? 32'(npc_q[rd_ptr_q]) : 32'h0;
  assign if_count  = count_q;

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    npc_d    = npc_q;
    tag_d    = tag_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    tag_rd_d = tag_rd_q;
    tag_wr_d = tag_wr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    outst_d  = outst_q + CW'(grant) - CW'(rsp_live);
    stale_d  = stale_q - CW'(imem_rvalid && (stale_q != '0));
    halted_d = halted_q || halt;

    if (grant) begin
      tag_d[tag_wr_q] = pc_q;
      tag_wr_d        = tag_wr_q + PW'(1);
      pc_d            = pc_q + AW'(1);
    end
    if (imem_rvalid) tag_rd_d = tag_rd_q + PW'(1);
    if (push) begin
      ir_d[wr_ptr_q]  = imem_rdata;
      npc_d[wr_ptr_q] = tag_q[tag_rd_q] + AW'(1);
      wr_ptr_d        = wr_ptr_q + PW'(1);
`ifdef FETCH_HLT_STOP_EN
      if (imem_rdata[31:26] == 6'b111111) halted_d = 1'b1;
`else
`endif
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    // Everything still owed becomes stale; a response arriving this cycle is already accounted.
    if (redirect) begin
      pc_d     = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      stale_d  = stale_q + outst_q - CW'(imem_rvalid);
      outst_d  = '0;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_q        <= AW'(RESET_PC);
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= '0;
        npc_q[i] <= '0;
        tag_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      tag_rd_q    <= '0;
      tag_wr_q    <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      stale_q     <= '0;
      halted_q    <= 1'b0;
      rst_state_q <= 1'b1;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      npc_q       <= npc_d;
      tag_q       <= tag_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      tag_rd_q    <= tag_rd_d;
      tag_wr_q    <= tag_wr_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      stale_q     <= stale_d;
      halted_q    <= halted_d;
      rst_state_q <= 1'b0;
    end
  end

  a_count_bound: assert property (@(posedge clk1) disable iff (rst)
    count_q <= CW'(DEPTH));
  a_inflight_bound: assert property (@(posedge clk1) disable iff (rst)
    ((CW+1)'(stale_q) + (CW+1)'(outst_q)) <= (CW+1)'(DEPTH));

endmodule
